medfilt: RTL and testbench

- Median-filter stage directly downstream of the sampler top.
- Consumes each finished measurement (one-cycle start pulse plus data word) and keeps a sliding window of the last WINDOW measurements.
- For each accepted measurement, computes the window median with a sequential rank scan and hands it to the control top with a one-cycle done pulse.
- Rejects measurements that arrive while a scan is in progress and reports them through a sticky overrun flag.

---
 rtl/medfilt.sv | 109 ++++++++++
 tb/tb_medfilt.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/medfilt.sv
// medfilt: sliding-window median of the last WINDOW measurements, found by a
// sequential rank scan that tests one candidate slot per cycle.
module medfilt #(
  parameter int MSB     = 15,
  parameter int WINDOW  = 5,
  parameter int MSB_IDX = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           samplertop_medtop_start,
  input  logic [MSB:0]   samplertop_medtop_data,
  input  logic           ctrltop_medtop_clear,
  output logic           medtop_ctrltop_done,
  output logic [MSB:0]   medtop_ctrltop_data,
  output logic           medtop_ctrltop_busy,
  output logic           medtop_ctrltop_overrun
);
  typedef enum logic {IDLE, SCAN} state_t;
  localparam logic [MSB_IDX:0] one  = 1;
  localparam logic [MSB_IDX:0] last = (MSB_IDX+1)'(WINDOW-1);
  localparam logic [MSB_IDX:0] full = (MSB_IDX+1)'(WINDOW);
  state_t state_q, state_d;
  logic [MSB:0] win_q [WINDOW];
  logic [MSB:0] win_d [WINDOW];
  logic [MSB_IDX:0] wptr_q, wptr_d, cnt_q, cnt_d, idx_q, idx_d, less, leq, rank;
  logic [MSB:0] cand, data_q, data_d;
  logic done_q, done_d, ovr_q, ovr_d, hit, accept;
  // rank of the current candidate among the valid slots
  always_comb begin
    cand = '0;
    less = '0;
    leq  = '0;
    for (int i = 0; i < WINDOW; i++)
      if (idx_q == (MSB_IDX+1)'(i)) cand = win_q[i];
    for (int i = 0; i < WINDOW; i++) begin
      if (i < int'(cnt_q)) begin
        less = less + {{MSB_IDX{1'b0}}, win_q[i] < cand};
        leq  = leq + {{MSB_IDX{1'b0}}, win_q[i] <= cand};
      end
    end
    rank = (cnt_q - one) >> 1;
    hit  = less <= rank && rank < leq;
  end
  always_comb begin
    accept  = state_q == IDLE && samplertop_medtop_start;
    state_d = state_q;
    wptr_d  = wptr_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    data_d  = data_q;
    done_d  = 1'b0;
    ovr_d   = ovr_q;
    for (int i = 0; i < WINDOW; i++)
      win_d[i] = accept && wptr_q == (MSB_IDX+1)'(i) ? samplertop_medtop_data : win_q[i];
    if (state_q == IDLE) begin
      if (samplertop_medtop_start) begin
        wptr_d  = wptr_q == last ? '0 : wptr_q + one;
        cnt_d   = cnt_q == full ? cnt_q : cnt_q + one;
        idx_d   = '0;
        state_d = SCAN;
      end
    end else begin
      ovr_d = ovr_q | samplertop_medtop_start;
      if (hit) begin
        data_d  = cand;
        done_d  = 1'b1;
        state_d = IDLE;
      end else begin
        idx_d = idx_q + one;
      end
    end
    // clear overrides everything, including a same-cycle start
    if (ctrltop_medtop_clear) begin
      for (int i = 0; i < WINDOW; i++) win_d[i] = win_q[i];
      state_d = IDLE;
      wptr_d  = '0;
      cnt_d   = '0;
      idx_d   = '0;
      data_d  = data_q;
      done_d  = 1'b0;
      ovr_d   = 1'b0;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      wptr_q  <= '0;
      cnt_q   <= '0;
      idx_q   <= '0;
      data_q  <= '0;
      done_q  <= 1'b0;
      ovr_q   <= 1'b0;
      for (int i = 0; i < WINDOW; i++) win_q[i] <= '0;
    end else begin
      state_q <= state_d;
      wptr_q  <= wptr_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      done_q  <= done_d;
      ovr_q   <= ovr_d;
      for (int i = 0; i < WINDOW; i++) win_q[i] <= win_d[i];
    end
  end
  assign medtop_ctrltop_done    = done_q;
  assign medtop_ctrltop_data    = data_q;
  assign medtop_ctrltop_busy    = state_q == SCAN;
  assign medtop_ctrltop_overrun = ovr_q;
endmodule

// File: tb/tb_medfilt.sv
// tb_medfilt: directed-vector bench for medfilt with hand-computed medians.
module tb_medfilt;
  logic clk = 0, rst_n = 0, start = 0, clear = 0;
  logic [15:0] din = 0, dout;
  logic done, busy, ovr;
  int total = 0, bad = 0, n;
  medfilt dut (
    .clk(clk), .rst_n(rst_n),
    .samplertop_medtop_start(start), .samplertop_medtop_data(din),
    .ctrltop_medtop_clear(clear),
    .medtop_ctrltop_done(done), .medtop_ctrltop_data(dout),
    .medtop_ctrltop_busy(busy), .medtop_ctrltop_overrun(ovr)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic send(input logic [15:0] d);
    start = 1;
    din = d;
    step();
    start = 0;
  endtask
  task automatic wait_done(output int k);
    k = 1;
    step();
    while (!done && k < 20) begin
      step();
      k++;
    end
  endtask
  task automatic run_med(input string tag, input logic [15:0] d, input logic [15:0] exp, output int k);
    send(d);
    wait_done(k);
    check({tag, "_done"}, done, 1);
    check(tag, dout, exp);
  endtask
  task automatic do_clear;
    clear = 1;
    step();
    clear = 0;
  endtask
  initial begin
    step();
    step();
    check("rst_done", done, 0);
    check("rst_data", dout, 0);
    check("rst_busy", busy, 0);
    check("rst_ovr", ovr, 0);
    rst_n = 1;
    step();
    send(16'h000A);
    check("t1_busy", busy, 1);
    wait_done(n);
    check("t1_lat", n, 1);
    check("t1_done", done, 1);
    check("t1_data", dout, 16'h000A);
    check("t1_busy_off", busy, 0);
    step();
    check("t1_done_pulse", done, 0);
    check("t1_hold", dout, 16'h000A);
    do_clear();
    run_med("s10", 10, 10, n);
    run_med("s50", 50, 10, n);
    run_med("s30", 30, 30, n);
    run_med("s20", 20, 20, n);
    run_med("s40", 40, 30, n);
    check("s40_lat", n, 3);
    run_med("wrap5", 5, 30, n);
    run_med("wrap60", 60, 30, n);
    do_clear();
    for (int i = 0; i < 5; i++) run_med("sev", 7, 7, n);
    run_med("ffff", 16'hFFFF, 7, n);
    run_med("z1", 0, 7, n);
    run_med("z2", 0, 7, n);
    run_med("z3", 0, 0, n);
    run_med("z4", 0, 0, n);
    do_clear();
    send(100);
    start = 1;
    din = 200;
    step();
    start = 0;
    check("ovr_done", done, 1);
    check("ovr_first", dout, 100);
    check("ovr_flag", ovr, 1);
    check("ovr_busy", busy, 0);
    run_med("ovr_drop", 150, 100, n);
    check("ovr_sticky", ovr, 1);
    do_clear();
    check("clr_ovr", ovr, 0);
    run_med("c5", 5, 5, n);
    run_med("c4", 4, 4, n);
    run_med("c3", 3, 4, n);
    send(1);
    clear = 1;
    step();
    clear = 0;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    step();
    step();
    step();
    check("abort_nodone", done, 0);
    check("abort_hold", dout, 4);
    run_med("after_abort", 99, 99, n);
    check("after_abort_lat", n, 1);
    clear = 1;
    start = 1;
    din = 33;
    step();
    clear = 0;
    start = 0;
    check("cs_busy", busy, 0);
    check("cs_ovr", ovr, 0);
    run_med("cs44", 44, 44, n);
    run_med("r55", 55, 44, n);
    send(50);
    start = 1;
    din = 1;
    step();
    start = 0;
    check("pre_rst_ovr", ovr, 1);
    check("pre_rst_busy", busy, 1);
    #2;
    rst_n = 0;
    #1;
    check("arst_done", done, 0);
    check("arst_data", dout, 0);
    check("arst_busy", busy, 0);
    check("arst_ovr", ovr, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
